// File: rtl/sb_config_loader_if.sv
// sb_config_loader_if: bitstream handshake, load control/status and SB programming bus (crc_err only with SB_CFG_CRC_EN)
interface sb_config_loader_if #(parameter int ADDR_W = 7);
  logic cfg_start, cfg_abort, bit_valid, bit_data, bit_ready;
  logic enable, data_in, busy, done;
  logic [0:ADDR_W-1] address;
  logic [7:0] bit_count;
`ifdef SB_CFG_CRC_EN
  logic crc_err;
  modport master (input cfg_start, cfg_abort, bit_valid, bit_data,
                  output bit_ready, enable, address, data_in, busy, done, bit_count, crc_err);
  modport slave (output cfg_start, cfg_abort, bit_valid, bit_data,
                 input bit_ready, enable, address, data_in, busy, done, bit_count, crc_err);
`else
  modport master (input cfg_start, cfg_abort, bit_valid, bit_data,
                  output bit_ready, enable, address, data_in, busy, done, bit_count);
  modport slave (output cfg_start, cfg_abort, bit_valid, bit_data,
                 input bit_ready, enable, address, data_in, busy, done, bit_count);
`endif
endinterface

// File: rtl/sb_config_loader.sv
// sb_config_loader: serial bitstream to SB enable/address/data_in sequencer, walks mux memories in decoder order; SB_CFG_CRC_EN adds a trailing CRC-8 check
module sb_config_loader #(
  parameter int ADDR_LO_W = 3,
  parameter int ADDR_HI_W = 4,
  parameter int NUM_MEMS = 15,
  parameter logic [4*NUM_MEMS-1:0] MEM_BITS = 60'h666222222222666
) (
  input logic prog_clk,
  input logic pReset,
  sb_config_loader_if.master sb
);
  localparam int MW = ADDR_HI_W + 1;
`ifdef SB_CFG_CRC_EN
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, STROBE, HOLD, DONE, CHECK} state_t;
  logic [7:0] crc, rx;
  logic [3:0] rx_cnt;
  logic chk, crc_err;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, STROBE, HOLD, DONE} state_t;
`endif
  state_t state, state_n;
  logic [MW-1:0] mem_idx, mem_nxt;
  logic [ADDR_LO_W-1:0] bit_idx;
  logic [0:ADDR_LO_W+ADDR_HI_W-1] addr;
  logic [7:0] count;
  logic data_q, accept, start, busy, drive, last_bit, last_all;
  function automatic logic [3:0] mem_len(input logic [MW-1:0] m);
    mem_len = 4'd0;
    for (int i = 0; i < NUM_MEMS; i++)
      if (m == MW'(i)) mem_len = MEM_BITS[4*i +: 4];
  endfunction
  // lowest memory at or above 'from' with a nonzero bit count; NUM_MEMS when none remain
  function automatic logic [MW-1:0] next_live(input logic [MW-1:0] from);
    next_live = MW'(NUM_MEMS);
    for (int i = NUM_MEMS - 1; i >= 0; i--)
      if (MW'(i) >= from && MEM_BITS[4*i +: 4] != 4'd0) next_live = MW'(i);
  endfunction
  assign busy = state != IDLE && state != DONE;
  assign start = (state == IDLE || state == DONE) && sb.cfg_start && !sb.cfg_abort;
  assign accept = state == FETCH && sb.bit_valid;
  assign drive = state == SETUP || state == STROBE || state == HOLD;
  assign last_bit = 5'(bit_idx) + 5'd1 >= 5'(mem_len(mem_idx));
  assign mem_nxt = next_live(mem_idx + MW'(1));
  assign last_all = last_bit && mem_nxt == MW'(NUM_MEMS);
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? FETCH : state;
`ifdef SB_CFG_CRC_EN
      FETCH: state_n = !accept ? FETCH : chk ? CHECK : SETUP;
      HOLD: state_n = FETCH;
      CHECK: state_n = rx_cnt == 4'd8 ? DONE : FETCH;
`else
      FETCH: state_n = accept ? SETUP : FETCH;
      HOLD: state_n = last_all ? DONE : FETCH;
`endif
      SETUP: state_n = STROBE;
      STROBE: state_n = HOLD;
      default: state_n = IDLE;
    endcase
    if (sb.cfg_abort && (busy || sb.cfg_start)) state_n = IDLE;
  end
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state <= IDLE;
      mem_idx <= '0;
      bit_idx <= '0;
      data_q <= 1'b0;
      count <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        mem_idx <= next_live('0);
        bit_idx <= '0;
        count <= '0;
      end
      if (accept) data_q <= sb.bit_data;
      if (state == STROBE) count <= count + 8'd1;
      if (state == HOLD) begin
        bit_idx <= last_bit ? '0 : bit_idx + ADDR_LO_W'(1);
        mem_idx <= last_bit ? mem_nxt : mem_idx;
      end
    end
  end
`ifdef SB_CFG_CRC_EN
  // payload bits feed the CRC; once chk is set, accepted bits are the received CRC, MSB first
  always_ff @(posedge prog_clk) begin
    if (pReset || start || sb.cfg_abort) begin
      crc <= '0;
      rx <= '0;
      rx_cnt <= '0;
      chk <= 1'b0;
      crc_err <= 1'b0;
    end else begin
      if (accept && !chk) crc <= {crc[6:0], 1'b0} ^ ({8{crc[7] ^ sb.bit_data}} & 8'h07);
      if (accept && chk) rx <= {rx[6:0], sb.bit_data};
      if (accept && chk) rx_cnt <= rx_cnt + 4'd1;
      if (state == HOLD && last_all) chk <= 1'b1;
      if (state == CHECK && rx_cnt == 4'd8) crc_err <= rx != crc;
    end
  end
  assign sb.crc_err = crc_err;
`endif
  always_comb begin
    addr = '0;
    for (int k = 0; k < ADDR_LO_W; k++) addr[k] = bit_idx[k];
    for (int j = 0; j < ADDR_HI_W; j++) addr[ADDR_LO_W+j] = mem_idx[ADDR_HI_W-1-j];
  end
  assign sb.address = drive ? addr : '0;
  assign sb.data_in = drive & data_q;
  assign sb.enable = state == STROBE;
  assign sb.bit_ready = state == FETCH;
  assign sb.busy = busy;
  assign sb.done = state == DONE;
  assign sb.bit_count = count;
endmodule

// File: tb/tb_sb_config_loader.sv
// tb_sb_config_loader: randomized directed bench, strobe order/data checked against a model built from MEM_BITS
module tb_sb_config_loader;
  localparam int AW = 7;
  localparam int NBITS = 54;
  localparam logic [59:0] MB0 = 60'h666222222222666;
  localparam logic [59:0] MB1 = 60'h666222222220666;
`ifdef SB_CFG_CRC_EN
  localparam int TAIL = 16;
`else
  localparam int TAIL = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0, cyc = 0, t0 = 0, sz = 0;
  int pat = 1, gap = 0;
  logic flip = 1'b0;
  logic [7:0] crc_ref = '0;
  logic acc[$];
  int sm[$], sbi[$];
  logic sd[$];
  int n1 = 0, m3 = 0, bad = 0;
  logic [0:AW-1] pa = '0;
  logic pd = 1'b0;
  sb_config_loader_if #(.ADDR_W(AW)) a ();
  sb_config_loader_if #(.ADDR_W(AW)) b ();
  sb_config_loader #(.MEM_BITS(MB0)) u0 (.prog_clk(clk), .pReset(rst), .sb(a));
  sb_config_loader #(.MEM_BITS(MB1)) u1 (.prog_clk(clk), .pReset(rst), .sb(b));
  always #5 clk = ~clk;
  function automatic int dec_mem(input logic [0:AW-1] ad);
    int r = 0;
    for (int j = 0; j < 4; j++) r = r * 2 + int'(ad[3+j]);
    return r;
  endfunction
  function automatic int dec_bit(input logic [0:AW-1] ad);
    return int'(ad[0]) + 2 * int'(ad[1]) + 4 * int'(ad[2]);
  endfunction
`ifdef SB_CFG_CRC_EN
  function automatic logic [7:0] alt_crc();
    logic r [0:NBITS+7];
    logic [8:0] g = 9'h107;
    logic [7:0] res = '0;
    for (int i = 0; i < NBITS + 8; i++) r[i] = i < NBITS && i % 2 == 0;
    for (int i = 0; i < NBITS; i++)
      if (r[i]) for (int j = 0; j <= 8; j++) r[i+j] ^= g[8-j];
    for (int t = 0; t < 8; t++) res = {res[6:0], r[NBITS+t]};
    return res;
  endfunction
`endif
  function automatic logic gen_bit(input int idx);
    if (pat == 1) return 1'b1;
    if (pat == 2) return idx < NBITS ? logic'(idx % 2 == 0) :
                         idx < NBITS + 8 ? crc_ref[7 - (idx - NBITS)] ^ (flip && idx == NBITS + 7) : 1'b0;
    return logic'($urandom_range(1));
  endfunction
  always @(negedge clk) begin
    if (a.enable === 1'b1) begin
      if (a.address !== pa || a.data_in !== pd) bad++;
      sm.push_back(dec_mem(a.address));
      sbi.push_back(dec_bit(a.address));
      sd.push_back(a.data_in);
    end
    pa = a.address;
    pd = a.data_in;
    if (b.enable === 1'b1) begin
      n1++;
      if (dec_mem(b.address) == 3) m3++;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    @(negedge clk);
    cyc++;
    a.bit_valid = gap == 0 || $urandom_range(99) >= gap;
    a.bit_data = gen_bit(acc.size());
    if (a.bit_ready === 1'b1 && a.bit_valid) acc.push_back(a.bit_data);
  endtask
  task automatic start_load(input int p, input int g);
    pat = p;
    gap = g;
    acc.delete();
    sm.delete();
    sbi.delete();
    sd.delete();
    a.cfg_start = 1'b1;
    cycle();
    a.cfg_start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int lim = cyc + 5000;
    while (a.done !== 1'b1 && cyc < lim) cycle();
    check({tag, " done"}, a.done, 1'b1);
  endtask
  task automatic wait_count(input string tag, input int n);
    int lim = cyc + 3000;
    while (int'(a.bit_count) != n && cyc < lim) cycle();
    check({tag, " reach count"}, a.bit_count, n);
  endtask
  task automatic check_idle(input string tag, input logic dn, input int cnt);
    check({tag, " enable"}, a.enable, 1'b0);
    check({tag, " address"}, a.address, '0);
    check({tag, " data_in"}, a.data_in, 1'b0);
    check({tag, " busy"}, a.busy, 1'b0);
    check({tag, " done"}, a.done, dn);
    check({tag, " bit_ready"}, a.bit_ready, 1'b0);
    if (cnt >= 0) check({tag, " bit_count"}, a.bit_count, cnt);
  endtask
  task automatic check_load(input string tag);
    logic [59:0] mb = MB0;
    int k = 0;
    check({tag, " strobe count"}, sm.size(), NBITS);
    for (int m = 0; m < 15; m++)
      for (int i = 0; i < int'(mb[4*m +: 4]); i++) begin
        if (k < sm.size() && k < acc.size()) begin
          check($sformatf("%s strobe %0d mem", tag, k), sm[k], m);
          check($sformatf("%s strobe %0d bit", tag, k), sbi[k], i);
          check($sformatf("%s strobe %0d data", tag, k), sd[k], acc[k]);
        end
        k++;
      end
  endtask
  initial begin
    a.cfg_start = 1'b0; a.cfg_abort = 1'b0; a.bit_valid = 1'b0; a.bit_data = 1'b0;
    b.cfg_start = 1'b0; b.cfg_abort = 1'b0; b.bit_valid = 1'b1; b.bit_data = 1'b1;
    repeat (3) cycle();
    check_idle("reset", 1'b0, 0);
    rst = 1'b0;
    cycle();
    t0 = cyc;
    n1 = 0;
    m3 = 0;
    b.cfg_start = 1'b1;
    start_load(1, 0);
    b.cfg_start = 1'b0;
    wait_done("ones");
    check("ones done cycle", cyc - t0, 1 + NBITS * 4 + TAIL);
    repeat (2) cycle();
    check("ones first strobe mem", sm.size() > 0 ? sm[0] : -1, 0);
    check("ones first strobe bit", sbi.size() > 0 ? sbi[0] : -1, 0);
    check("ones 7th strobe mem", sm.size() > 6 ? sm[6] : -1, 1);
    check("ones 7th strobe bit", sbi.size() > 6 ? sbi[6] : -1, 0);
    check_load("ones");
    check_idle("ones after", 1'b1, NBITS);
    sz = acc.size();
    repeat (4) cycle();
    check("done no extra accept", acc.size(), sz);
    check("done held", a.done, 1'b1);
    check("skip strobes", n1, 52);
    check("skip mem3 strobes", m3, 0);
    check("skip bit_count", b.bit_count, 52);
    check("skip done", b.done, 1'b1);
    start_load(0, 40);
    wait_done("bp");
    repeat (2) cycle();
    check_load("bp");
    start_load(0, 30);
    wait_count("abort", 20);
    a.cfg_abort = 1'b1;
    cycle();
    a.cfg_abort = 1'b0;
    check_idle("abort", 1'b0, -1);
    start_load(0, 30);
    wait_count("restart", 5);
    a.cfg_start = 1'b1;
    cycle();
    a.cfg_start = 1'b0;
    check("start while busy count", a.bit_count, 5);
    check("start while busy busy", a.busy, 1'b1);
    wait_done("restart");
    repeat (2) cycle();
    check_load("restart");
    start_load(0, 0);
    repeat (10) cycle();
    a.cfg_start = 1'b1;
    a.cfg_abort = 1'b1;
    cycle();
    a.cfg_start = 1'b0;
    a.cfg_abort = 1'b0;
    check_idle("start+abort busy", 1'b0, -1);
    cycle();
    check("start+abort stays idle", a.busy, 1'b0);
    start_load(1, 0);
    wait_done("pre start+abort");
    a.cfg_start = 1'b1;
    a.cfg_abort = 1'b1;
    cycle();
    a.cfg_start = 1'b0;
    a.cfg_abort = 1'b0;
    check_idle("start+abort done", 1'b0, -1);
    cycle();
    check("start+abort done stays idle", a.bit_ready, 1'b0);
    start_load(0, 0);
    t0 = cyc + 200;
    while (a.enable !== 1'b1 && cyc < t0) cycle();
    check("reset strobe reached", a.enable, 1'b1);
    rst = 1'b1;
    cycle();
    check_idle("reset mid-strobe", 1'b0, 0);
    rst = 1'b0;
    sz = sm.size();
    repeat (8) cycle();
    check("no strobe after reset", sm.size(), sz);
    check("idle after reset", a.busy, 1'b0);
`ifdef SB_CFG_CRC_EN
    crc_ref = alt_crc();
    flip = 1'b0;
    start_load(2, 0);
    wait_done("crc good");
    check("crc good err", a.crc_err, 1'b0);
    flip = 1'b1;
    start_load(2, 25);
    wait_done("crc bad");
    check("crc bad err", a.crc_err, 1'b1);
    check("crc bad done", a.done, 1'b1);
    a.cfg_abort = 1'b1;
    cycle();
    a.cfg_abort = 1'b0;
    check("crc err cleared by abort", a.crc_err, 1'b0);
`endif
    check("enable with bus change", bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
